// File: rtl/ir_sense_seq.sv
// Per-frame IR wall-sensor sequencer: emitter settle, left/right A2D req/ack, open flags and saturated derivative.
// Latency: vld one clock after the right ack. A2D ack latency is unbounded; frame ticks that arrive while busy are dropped and flagged on ovr.
module ir_sense_seq #(
  parameter int          FRAME_CYC  = 4096,
  parameter int          SETTLE_CYC = 64,
  parameter logic [11:0] OPN_THRES  = 12'h600,
  parameter logic [2:0]  LFT_CHNL   = 3'd4,
  parameter logic [2:0]  RGHT_CHNL  = 3'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              a2d_req,
  output logic [2:0]        a2d_chnl,
  input  logic              a2d_ack,
  input  logic [11:0]       a2d_res,
  output logic              IR_en,
  output logic [11:0]       lft_IR,
  output logic [11:0]       rght_IR,
  output logic              lft_opn,
  output logic              rght_opn,
  output logic signed [8:0] IR_Dtrm,
  output logic              vld,
  output logic              ovr
);

  localparam int FW = $clog2(FRAME_CYC);
  localparam int SW = $clog2(SETTLE_CYC) + 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_CYC - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, REQ_L, GAP, REQ_R, UPDATE} state_t;

  state_t            state, state_nxt;
  logic [FW-1:0]     frm_cnt;
  logic [SW-1:0]     set_cnt;
  logic [11:0]       lft_reg;
  logic signed [12:0] err_prev;
  logic              first_frm;
  logic              tick, start, cap_l, upd;

  assign tick = en && (frm_cnt == FRM_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            frm_cnt <= '0;
    else if (!en || tick)  frm_cnt <= '0;
    else                   frm_cnt <= frm_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    a2d_req   = 1'b0;
    a2d_chnl  = 3'd0;
    vld       = 1'b0;
    ovr       = tick && (state != IDLE);
    start     = 1'b0;
    cap_l     = 1'b0;
    upd       = 1'b0;
    case (state)
      IDLE:   if (tick) begin state_nxt = SETTLE; start = 1'b1; end
      SETTLE: if (set_cnt == SET_LAST) state_nxt = REQ_L;
      REQ_L: begin
        a2d_req  = 1'b1;
        a2d_chnl = LFT_CHNL;
        if (a2d_ack) begin state_nxt = GAP; cap_l = 1'b1; end
      end
      GAP:    state_nxt = REQ_R;
      REQ_R: begin
        a2d_req  = 1'b1;
        a2d_chnl = RGHT_CHNL;
        if (a2d_ack) begin state_nxt = UPDATE; upd = 1'b1; end
      end
      UPDATE: begin vld = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
    // Disable aborts the sequence; any ack arriving now is ignored.
    if (!en) begin
      state_nxt = IDLE;
      start     = 1'b0;
      cap_l     = 1'b0;
      upd       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           IR_en <= 1'b0;
    else if (start)       IR_en <= 1'b1;
    else if (upd || !en)  IR_en <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 set_cnt <= '0;
    else if (start)             set_cnt <= '0;
    else if (state == SETTLE)   set_cnt <= set_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lft_reg <= '0;
    else if (cap_l) lft_reg <= a2d_res;
  end

  logic               lo_new, ro_new;
  logic signed [12:0] err_new;
  logic signed [13:0] d_full;
  logic signed [8:0]  d_sat;

  always_comb begin
    lo_new  = (lft_reg < OPN_THRES);
    ro_new  = (a2d_res < OPN_THRES);
    err_new = $signed({1'b0, lft_reg}) - $signed({1'b0, a2d_res});
    d_full  = $signed({err_new[12], err_new}) - $signed({err_prev[12], err_prev});
    // Clamp on the full 14-bit difference so large swings never wrap.
    if (d_full > 14'sd255)       d_sat = 9'sd255;
    else if (d_full < -14'sd256) d_sat = -9'sd256;
    else                         d_sat = d_full[8:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_IR    <= '0;
      rght_IR   <= '0;
      lft_opn   <= 1'b0;
      rght_opn  <= 1'b0;
      IR_Dtrm   <= '0;
      err_prev  <= '0;
      first_frm <= 1'b1;
    end else if (upd) begin
      lft_IR    <= lft_reg;
      rght_IR   <= a2d_res;
      lft_opn   <= lo_new;
      rght_opn  <= ro_new;
      IR_Dtrm   <= (first_frm || lo_new || ro_new) ? 9'sd0 : d_sat;
      err_prev  <= err_new;
      first_frm <= 1'b0;
    end
  end

endmodule
